sayac_wb_arbiter: RTL and testbench

SAYAC_WB_ARBITER -- requirements
Module: sayac_wb_arbiter

---
 rtl/sayac_wb_arbiter.sv | 133 +++++++++++++
 tb/tb_sayac_wb_arbiter.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sayac_wb_arbiter.sv
// Three-source writeback arbiter for the SAYAC register file: one-entry buffer
// per source, round-robin grant into a registered writeback stage.
module sayac_wb_arbiter #(
  parameter int N  = 16,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req1,
  input  logic          req2,
  input  logic          req3,
  input  logic [N-1:0]  data1,
  input  logic [N-1:0]  data2,
  input  logic [N-1:0]  data3,
  input  logic [AW-1:0] addr1,
  input  logic [AW-1:0] addr2,
  input  logic [AW-1:0] addr3,
  output logic          ack1,
  output logic          ack2,
  output logic          ack3,
  input  logic          rfBusy,
  output logic          sel1,
  output logic          sel2,
  output logic          sel3,
  output logic [N-1:0]  wbData,
  output logic [AW-1:0] wbAddr,
  output logic          wbEn
);

  typedef enum logic {IDLE, WRITE} state_t;

  state_t        state, state_n;
  logic [2:0]    req, ack, full, sel, sel_n;
  logic [N-1:0]  din  [3];
  logic [AW-1:0] ain  [3];
  logic [N-1:0]  bdata [3];
  logic [AW-1:0] baddr [3];
  logic [N-1:0]  wbdata_n;
  logic [AW-1:0] wbaddr_n;
  logic [1:0]    last, last_n, gidx, cand;
  logic          gvalid, grant, opp;

  assign req    = {req3, req2, req1};
  assign din[0] = data1;
  assign din[1] = data2;
  assign din[2] = data3;
  assign ain[0] = addr1;
  assign ain[1] = addr2;
  assign ain[2] = addr3;

  // rst gates ack so sources see no handshake while held in reset
  assign ack  = req & ~full & {3{rst}};
  assign ack1 = ack[0];
  assign ack2 = ack[1];
  assign ack3 = ack[2];

  assign sel1 = sel[0];
  assign sel2 = sel[1];
  assign sel3 = sel[2];
  assign wbEn = (state == WRITE);

  assign opp = (state == IDLE) || !rfBusy;

  // search order last+1, last+2, last+3 over indices 0..2 (sources 1..3)
  always_comb begin
    gvalid = 1'b0;
    gidx   = last;
    cand   = '0;
    for (int unsigned i = 1; i <= 3; i++) begin
      cand = 2'((32'(last) + i) % 3);
      if (!gvalid && full[cand]) begin
        gvalid = 1'b1;
        gidx   = cand;
      end
    end
  end

  always_comb begin
    state_n  = state;
    sel_n    = sel;
    wbdata_n = wbData;
    wbaddr_n = wbAddr;
    last_n   = last;
    grant    = 1'b0;
    if (opp) begin
      if (gvalid) begin
        state_n  = WRITE;
        sel_n    = 3'b001 << gidx;
        wbdata_n = bdata[gidx];
        wbaddr_n = baddr[gidx];
        last_n   = gidx;
        grant    = 1'b1;
      end else begin
        state_n = IDLE;
        sel_n   = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      sel    <= '0;
      wbData <= '0;
      wbAddr <= '0;
      last   <= 2'd2;
    end else begin
      state  <= state_n;
      sel    <= sel_n;
      wbData <= wbdata_n;
      wbAddr <= wbaddr_n;
      last   <= last_n;
    end
  end

  // ack needs an empty buffer and grant needs a full one, so they never collide
  for (genvar k = 0; k < 3; k++) begin : g_buf
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        full[k]  <= 1'b0;
        bdata[k] <= '0;
        baddr[k] <= '0;
      end else if (ack[k]) begin
        full[k]  <= 1'b1;
        bdata[k] <= din[k];
        baddr[k] <= ain[k];
      end else if (grant && gidx == 2'(k)) begin
        full[k] <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sayac_wb_arbiter.sv
// Bench for sayac_wb_arbiter: transaction-level model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_sayac_wb_arbiter;
  localparam int N  = 16;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req1 = 0, req2 = 0, req3 = 0, rfBusy = 0;
  logic [N-1:0]  data1 = '0, data2 = '0, data3 = '0;
  logic [AW-1:0] addr1 = '0, addr2 = '0, addr3 = '0;
  logic          ack1, ack2, ack3, sel1, sel2, sel3, wbEn;
  logic [N-1:0]  wbData;
  logic [AW-1:0] wbAddr;

  int total = 0;
  int bad   = 0;

  sayac_wb_arbiter #(.N(N), .AW(AW)) dut (
    .clk(clk), .rst(rst),
    .req1(req1), .req2(req2), .req3(req3),
    .data1(data1), .data2(data2), .data3(data3),
    .addr1(addr1), .addr2(addr2), .addr3(addr3),
    .ack1(ack1), .ack2(ack2), .ack3(ack3),
    .rfBusy(rfBusy),
    .sel1(sel1), .sel2(sel2), .sel3(sel3),
    .wbData(wbData), .wbAddr(wbAddr), .wbEn(wbEn)
  );

  initial forever #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- model ----------------
  typedef struct {int src; logic [N-1:0] d; logic [AW-1:0] a;} wr_t;
  wr_t           log_q[$];
  bit            m_full [3];
  logic [N-1:0]  m_d [3];
  logic [AW-1:0] m_a [3];
  bit            m_wr;
  int            m_sel, m_last;
  logic [N-1:0]  m_wd;
  logic [AW-1:0] m_wa;

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m_full[k] = 0; m_d[k] = '0; m_a[k] = '0;
    end
    m_wr = 0; m_sel = 0; m_last = 2; m_wd = '0; m_wa = '0;
  endtask

  task automatic compare();
    logic [2:0] rq, ea, es;
    rq = {req3, req2, req1};
    for (int k = 0; k < 3; k++) ea[k] = rst && rq[k] && !m_full[k];
    es = m_wr ? (3'b100 >> m_sel) : 3'b000;
    chk("ack",    {29'd0, ack3, ack2, ack1}, {29'd0, ea});
    chk("wbEn",   {31'd0, wbEn}, {31'd0, m_wr});
    chk("sel",    {29'd0, sel1, sel2, sel3}, {29'd0, es});
    chk("wbData", {16'd0, wbData}, {16'd0, m_wd});
    chk("wbAddr", {28'd0, wbAddr}, {28'd0, m_wa});
  endtask

  task automatic model_step();
    logic [2:0]    rq;
    bit            ak [3];
    logic [N-1:0]  dv [3];
    logic [AW-1:0] av [3];
    bit            found;
    rq = {req3, req2, req1};
    dv[0] = data1; dv[1] = data2; dv[2] = data3;
    av[0] = addr1; av[1] = addr2; av[2] = addr3;
    for (int k = 0; k < 3; k++) ak[k] = rq[k] && !m_full[k];
    if (m_wr && !rfBusy) log_q.push_back('{m_sel + 1, m_wd, m_wa});
    if (!m_wr || !rfBusy) begin
      found = 0;
      for (int d = 1; d <= 3; d++) begin
        int k;
        k = (m_last + d) % 3;
        if (!found && m_full[k]) begin
          found = 1; m_wr = 1; m_sel = k; m_last = k;
          m_wd = m_d[k]; m_wa = m_a[k]; m_full[k] = 0;
        end
      end
      if (!found) m_wr = 0;
    end
    for (int k = 0; k < 3; k++)
      if (ak[k]) begin
        m_full[k] = 1; m_d[k] = dv[k]; m_a[k] = av[k];
      end
  endtask

  initial begin
    model_reset();
    forever begin
      @(negedge clk);
      if (!rst) model_reset();
      compare();
      if (rst) model_step();
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    req1 = 0; req2 = 0; req3 = 0; rfBusy = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 0;
    tick();
    tick();
    rst = 1;
    log_q.delete();
  endtask

  initial begin
    int n1, n3;
    #2 rst = 0;
    tick();
    chk("rst_wbEn",   {31'd0, wbEn}, 32'd0);
    chk("rst_sel",    {29'd0, sel1, sel2, sel3}, 32'd0);
    chk("rst_wbData", {16'd0, wbData}, 32'd0);
    tick();
    rst = 1;

    // single source on port 2
    req2 = 1; data2 = 16'h00A5; addr2 = 4'h3;
    #1 chk("s1_ack2_c0", {31'd0, ack2}, 32'd1);
    tick(); req2 = 0;
    tick();
    chk("s1_wbEn_c2",   {31'd0, wbEn}, 32'd1);
    chk("s1_sel_c2",    {29'd0, sel1, sel2, sel3}, 32'b010);
    chk("s1_wbData_c2", {16'd0, wbData}, 32'h00A5);
    chk("s1_wbAddr_c2", {28'd0, wbAddr}, 32'h3);
    tick();
    chk("s1_wbEn_c3",   {31'd0, wbEn}, 32'd0);
    chk("s1_hold_c3",   {16'd0, wbData}, 32'h00A5);

    // all three at once after reset
    do_reset();
    req1 = 1; data1 = 16'h1111; addr1 = 4'h1;
    req2 = 1; data2 = 16'h2222; addr2 = 4'h2;
    req3 = 1; data3 = 16'h3333; addr3 = 4'h3;
    tick(); clear_inputs();
    tick();
    chk("s2_sel_c2", {29'd0, sel1, sel2, sel3}, 32'b100);
    chk("s2_dat_c2", {16'd0, wbData}, 32'h1111);
    tick();
    chk("s2_sel_c3", {29'd0, sel1, sel2, sel3}, 32'b010);
    tick();
    chk("s2_sel_c4", {29'd0, sel1, sel2, sel3}, 32'b001);
    chk("s2_dat_c4", {16'd0, wbData}, 32'h3333);
    tick();
    chk("s2_wbEn_c5", {31'd0, wbEn}, 32'd0);

    // rfBusy stall (also high in IDLE, where it is ignored)
    log_q.delete();
    req1 = 1; data1 = 16'h1234; addr1 = 4'h5;
    tick(); req1 = 0; rfBusy = 1;
    for (int c = 2; c <= 4; c++) begin
      tick();
      chk("s3_wbEn_busy", {31'd0, wbEn}, 32'd1);
      chk("s3_sel_busy",  {29'd0, sel1, sel2, sel3}, 32'b100);
      chk("s3_dat_busy",  {16'd0, wbData}, 32'h1234);
    end
    tick(); rfBusy = 0;
    chk("s3_wbEn_c5", {31'd0, wbEn}, 32'd1);
    chk("s3_log_c5",  32'(log_q.size()), 32'd0);
    tick();
    chk("s3_wbEn_c6", {31'd0, wbEn}, 32'd0);
    chk("s3_log_c6",  32'(log_q.size()), 32'd1);

    // two persistent requesters alternate
    do_reset();
    n1 = 0; n3 = 0;
    addr1 = 4'h1; addr3 = 4'h3;
    for (int c = 0; c < 10; c++) begin
      req1 = 1; req3 = 1;
      data1 = 16'(16'h1000 + n1);
      data3 = 16'(16'h3000 + n3);
      #1;
      if (ack1) n1++;
      if (ack3) n3++;
      tick();
    end
    clear_inputs();
    repeat (4) tick();
    chk("s4_log_size", {31'd0, log_q.size() >= 6}, 32'd1);
    if (log_q.size() >= 6)
      for (int i = 0; i < 6; i++) begin
        chk("s4_src", 32'(log_q[i].src), (i % 2 == 0) ? 32'd1 : 32'd3);
        chk("s4_dat", {16'd0, log_q[i].d},
            (i % 2 == 0) ? 32'h1000 + 32'(i / 2) : 32'h3000 + 32'(i / 2));
      end

    // full buffer back-pressure, in-order delivery
    do_reset();
    req1 = 1; data1 = 16'h0101; addr1 = 4'h7;
    #1 chk("s5_ack1_c0", {31'd0, ack1}, 32'd1);
    tick(); data1 = 16'h0202;
    #1 chk("s5_ack1_c1", {31'd0, ack1}, 32'd0);
    tick();
    chk("s5_ack1_c2", {31'd0, ack1}, 32'd1);
    chk("s5_dat_c2",  {16'd0, wbData}, 32'h0101);
    tick(); req1 = 0;
    chk("s5_wbEn_c3", {31'd0, wbEn}, 32'd0);
    tick();
    chk("s5_dat_c4",  {16'd0, wbData}, 32'h0202);
    tick(); tick();
    chk("s5_log_n", 32'(log_q.size()), 32'd2);
    if (log_q.size() == 2) begin
      chk("s5_log0", {16'd0, log_q[0].d}, 32'h0101);
      chk("s5_log1", {16'd0, log_q[1].d}, 32'h0202);
    end

    // reset while busy writing with buffers full
    do_reset();
    req1 = 1; data1 = 16'h0A0A; addr1 = 4'h1;
    req2 = 1; data2 = 16'h0B0B; addr2 = 4'h2;
    tick(); req2 = 0; data1 = 16'h0A0B;
    tick(); rfBusy = 1;
    tick(); req1 = 0;
    chk("s6_pre_wbEn", {31'd0, wbEn}, 32'd1);
    #2 rst = 0; req3 = 1;
    #1;
    chk("s6_rst_wbEn", {31'd0, wbEn}, 32'd0);
    chk("s6_rst_sel",  {29'd0, sel1, sel2, sel3}, 32'd0);
    chk("s6_rst_dat",  {16'd0, wbData}, 32'd0);
    chk("s6_rst_adr",  {28'd0, wbAddr}, 32'd0);
    chk("s6_rst_ack3", {31'd0, ack3}, 32'd0);
    tick(); tick();
    clear_inputs();
    rst = 1;
    for (int c = 0; c < 4; c++) begin
      tick();
      chk("s6_quiet", {31'd0, wbEn}, 32'd0);
    end
    req3 = 1; data3 = 16'h3C3C; addr3 = 4'h9;
    tick(); req3 = 0;
    tick();
    chk("s6_new_sel", {29'd0, sel1, sel2, sel3}, 32'b001);
    chk("s6_new_dat", {16'd0, wbData}, 32'h3C3C);
    repeat (3) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: run did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
